// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer: tag allocation, CDB capture, in-order commit
module reorder_buffer #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             issue,
    input  logic [REG_WIDTH-1:0]             issue_r0,
    output logic                             issue_ready,
    output logic [ROB_WIDTH-1:0]             issue_tag,
    input  logic                             cdb_valid,
    input  logic [ROB_WIDTH-1:0]             cdb_tag,
    input  logic [31:0]                      cdb_data,
    input  logic [1:0][ROB_WIDTH-1:0]        read_tag,
    output logic [1:0]                       read_done,
    output logic [1:0][31:0]                 read_data,
    output logic                             commit,
    output logic [ROB_WIDTH-1:0]             commit_tag,
    output logic [REG_WIDTH-1:0]             commit_r0,
    output logic [31:0]                      commit_data
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam int CW    = ROB_WIDTH + 1;

    logic [DEPTH-1:0]     busy_q, busy_d;
    logic [DEPTH-1:0]     done_q, done_d;
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [REG_WIDTH-1:0] r0_q   [DEPTH];
    logic [31:0]          data_q [DEPTH];

    logic issue_acc;
    logic cdb_wr;

    assign issue_ready = (count_q != CW'(DEPTH));
    assign issue_tag   = tail_q;
    assign issue_acc   = issue && issue_ready;
    // A broadcast colliding with the slot being allocated is stale; allocation wins.
    assign cdb_wr      = cdb_valid && busy_q[cdb_tag] && !(issue_acc && (cdb_tag == tail_q));

    assign commit      = busy_q[head_q] && done_q[head_q] && !flush;
    assign commit_tag  = head_q;
    assign commit_r0   = r0_q[head_q];
    assign commit_data = data_q[head_q];

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(issue_acc) - CW'(commit);
        if (commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        if (cdb_wr) begin
            done_d[cdb_tag] = 1'b1;
        end
        if (issue_acc) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + 1'b1;
        end
        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload fields are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && issue_acc) begin
            r0_q[tail_q] <= issue_r0;
        end
        if (!rst && !flush && cdb_wr) begin
            data_q[cdb_tag] <= cdb_data;
        end
    end

    always_comb begin
        read_done = '0;
        read_data = '0;
        for (int i = 0; i < 2; i++) begin
            if (cdb_valid && (cdb_tag == read_tag[i])) begin
                read_done[i] = 1'b1;
                read_data[i] = cdb_data;
            end else begin
                read_done[i] = busy_q[read_tag[i]] && done_q[read_tag[i]];
                read_data[i] = data_q[read_tag[i]];
            end
        end
    end
endmodule
